// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per clock, start/done handshake.
// Optional macro ZERO_BYPASS_EN: a zero operand completes in one cycle without entering RUN.
module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    m_q, m_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    q_q, q_d;
  logic            cy_q, cy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*N-1:0]  p_q, p_d;
  logic [N:0]      sum;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
    // Full N+1-bit add so the carry out of ACC is kept for the shift.
    sum     = {cy_q, acc_q} + {1'b0, (q_q[0] ? m_q : {N{1'b0}})};

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ZERO_BYPASS_EN
          if ((A == '0) || (B == '0)) begin
            p_d    = '0;
            done_d = 1'b1;
          end else begin
            m_d     = A;
            q_d     = B;
            acc_d   = '0;
            cy_d    = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
`else
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cy_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        acc_d = sum[N:1];
        q_d   = {sum[0], q_q[N-1:1]};
        cy_d  = 1'b0;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          p_d     = {sum[N:1], sum[0], q_q[N-1:1]};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule
